// File: rtl/arb_pkg.sv
// Shared types, widths and the rotating priority search for the round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // Rotate req so ptr sits at bit 0, find the lowest set bit, then add ptr back (mod NUM_REQ).
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [IDX_W-1:0]     off;
        dbl = {req, req};
        rot = NUM_REQ'(dbl >> ptr);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        return IDX_W'(off + ptr);
    endfunction

endpackage

// File: rtl/threexeight_decoder.sv
// 3-to-8 one-hot decoder with an enable; all-zero output when disabled.
module threexeight_decoder (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Eight-way round-robin arbiter with bounded tenure (MAX_HOLD cycles) and a
// mandatory RELEASE + IDLE gap between tenures. All outputs come straight from flops.
module onehot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       forced_release
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
        $error("onehot_rr_arbiter: MAX_HOLD must be in 2..256");
    end

    arb_state_e          state_q,        state_d;
    logic [IDX_W-1:0]    ptr_q,          ptr_d;
    logic [IDX_W-1:0]    grant_idx_q,    grant_idx_d;
    logic [HOLD_W-1:0]   hold_cnt_q,     hold_cnt_d;
    logic [NUM_REQ-1:0]  grant_q,        grant_d;
    logic                grant_valid_q,  grant_valid_d;
    logic                forced_q,       forced_d;
    logic                grant_en_d;
    logic [NUM_REQ-1:0]  grant_dec;

    // Decode the next-cycle index so the grant vector itself can be registered.
    threexeight_decoder u_dec (
        .idx    (grant_idx_d),
        .en     (grant_en_d),
        .onehot (grant_dec)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        hold_cnt_d  = hold_cnt_q;
        forced_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_idx_d = rr_pick(req, ptr_q);
                    hold_cnt_d  = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                // A dropped request wins over expiry, so no forced pulse in that case.
                if (!req[grant_idx_q]) begin
                    state_d = ST_RELEASE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d  = ST_RELEASE;
                    forced_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                ptr_d   = grant_idx_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        grant_en_d    = (state_d == ST_GRANT);
        grant_valid_d = grant_en_d;
        grant_d       = grant_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_idx_q   <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            forced_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            forced_q      <= forced_d;
        end
    end

    assign grant          = grant_q;
    assign grant_idx      = grant_idx_q;
    assign grant_valid    = grant_valid_q;
    assign forced_release = forced_q;

endmodule

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive grant cycles per tenure; legal range 2..256.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  8  request vector; bit i high = requester i wants the shared resource.
REQ-005 Port: grant  output  8  one-hot grant vector; all-zero when no grant.
REQ-006 Port: grant_idx  output  3  binary index of current/last granted requester.
REQ-007 Port: grant_valid  output  1  high exactly when grant is non-zero.
REQ-008 Port: forced_release  output  1  one-cycle pulse when a tenure ends by MAX_HOLD expiry.

Function
REQ-009 FSM states SHALL be IDLE, GRANT, RELEASE; all outputs SHALL be registered or decoded from registered state only, with no combinational path from req to any output.
REQ-010 IDLE: if req != 0, the block SHALL select the first set bit searching upward from ptr with wrap 7->0, load grant_idx, clear hold_cnt and enter GRANT; if req == 0, it SHALL remain in IDLE.
REQ-011 Latency: grant SHALL assert on the cycle after the IDLE cycle in which req was sampled non-zero (one-cycle request-to-grant).
REQ-012 GRANT: grant SHALL equal the 3-to-8 one-hot decode of grant_idx, grant_valid = 1, and hold_cnt SHALL increment each cycle.
REQ-013 GRANT exit: if req[grant_idx] == 0, or if hold_cnt == MAX_HOLD-1, the next state SHALL be RELEASE; req drop takes priority over expiry when both occur in the same cycle (forced_release = 0).
REQ-014 A tenure SHALL therefore last at most MAX_HOLD cycles.
REQ-015 RELEASE: grant = 0, grant_valid = 0, ptr SHALL become (grant_idx + 1) mod 8, and the next state SHALL be IDLE unconditionally.
REQ-016 forced_release SHALL be high only during the RELEASE cycle that follows an expiry exit with req[grant_idx] still high.
REQ-017 grant_idx SHALL hold its value in RELEASE and IDLE until the next arbitration.
REQ-018 Requests from non-granted bits arriving during GRANT SHALL be ignored until the next IDLE evaluation; no pre-emption.
REQ-019 A requester re-requesting after its own tenure SHALL be served after all other pending requesters, because ptr starts at the next index.
REQ-020 Minimum gap between consecutive tenures SHALL be 2 cycles (RELEASE + IDLE).

Reset
REQ-021 On rst = 1 at a clock edge: state = IDLE, ptr = 0, grant_idx = 0, hold_cnt = 0, grant = 8'h00, grant_valid = 0, forced_release = 0.
REQ-022 Reset asserted mid-GRANT SHALL drop grant on the following edge with no RELEASE cycle and no forced_release pulse.
REQ-023 On the first cycle after rst deasserts, the block SHALL be in IDLE and SHALL evaluate req normally.

Structure
REQ-024 Package arb_pkg SHALL hold the FSM state enum, NUM_REQ = 8, IDX_W = 3 and HOLD_W = 8.
REQ-025 Decoding of grant_idx to grant SHALL use one instance of the team's existing threexeight_decoder, gated by the GRANT state.
REQ-026 The priority search from ptr SHALL be implemented as a rotate / find-first / unrotate function inside arb_pkg or local to the module; no further sub-modules.

Verification
REQ-027 After reset, req = 8'h08 -> grant = 8'h08 and grant_idx = 3 one cycle later; drop req -> RELEASE (grant 0) -> IDLE.
REQ-028 req = 8'hFF held, MAX_HOLD = 4 -> grants in order 0,1,2,...,7,0; each tenure lasts 4 cycles with forced_release pulsed; 2-cycle gaps between tenures.
REQ-029 Only req[5] held for 40 cycles, MAX_HOLD = 16 -> grant 8'h20 for 16 cycles, 2 cycles low, then regranted; forced_release pulses twice.
REQ-030 req[2] granted; in the same cycle that hold_cnt = MAX_HOLD-1, req[2] drops -> RELEASE with forced_release = 0.
REQ-031 rst asserted during a grant to index 6 -> next cycle grant = 0 and ptr = 0; with req = 8'h41 after reset, index 0 is granted first.
REQ-032 Every cycle the bench SHALL check that grant is one-hot or zero, that grant_valid == |grant, and that grant is zero whenever the last-sampled req is zero.
